// File: rtl/pool_ctrl.sv
// Max-pooling sequencer: scans an input map window by window, strobes the pooling
// unit's clear on each window's first element and writes one maximum per window.
module pool_ctrl #(
  parameter int MAP_W = 28,
  parameter int MAP_H = 28,
  parameter int WIN   = 2,
  parameter int RD_AW = 10,
  parameter int WR_AW = 8,
  parameter int DW    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             rd_en_o,
  output logic [RD_AW-1:0] rd_addr_o,
  output logic             pool_clr_o,
  input  logic [DW-1:0]    pool_dout_i,
  output logic             wr_en_o,
  output logic [WR_AW-1:0] wr_addr_o,
  output logic [DW-1:0]    wr_data_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int OW  = MAP_W / WIN;
  localparam int OH  = MAP_H / WIN;
  localparam int WCW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int OCW = (OW > 1) ? $clog2(OW) : 1;
  localparam int ORW = (OH > 1) ? $clog2(OH) : 1;

  localparam logic [WCW-1:0]   WIN_MAX    = WCW'(WIN - 1);
  localparam logic [OCW-1:0]   OC_MAX     = OCW'(OW - 1);
  localparam logic [ORW-1:0]   OR_MAX     = ORW'(OH - 1);
  localparam logic [RD_AW-1:0] STEP_ROW   = RD_AW'(MAP_W);
  localparam logic [RD_AW-1:0] STEP_WIN   = RD_AW'(WIN);
  localparam logic [RD_AW-1:0] STEP_STRIP = RD_AW'(WIN * MAP_W);

  state_t           state_q, state_d;
  logic             drain_q, drain_d;
  logic [WCW-1:0]   win_col_q, win_col_d;
  logic [WCW-1:0]   win_row_q, win_row_d;
  logic [OCW-1:0]   out_col_q, out_col_d;
  logic [ORW-1:0]   out_row_q, out_row_d;
  logic [RD_AW-1:0] rd_addr_q, rd_addr_d;
  logic [RD_AW-1:0] row_base_q, row_base_d;
  logic [RD_AW-1:0] win_base_q, win_base_d;
  logic [RD_AW-1:0] strip_base_q, strip_base_d;
  logic             clr_q, clr_d;
  logic             last_q, last_d;
  logic             wen_q, wen_d;
  logic [WR_AW-1:0] wr_addr_q, wr_addr_d;

  logic run;
  logic win_last;
  logic scan_end;

  assign run      = (state_q == S_RUN);
  assign win_last = (win_col_q == WIN_MAX) && (win_row_q == WIN_MAX);
  assign scan_end = win_last && (out_col_q == OC_MAX) && (out_row_q == OR_MAX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (scan_end) state_d = S_DRAIN;
      S_DRAIN: if (drain_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q != S_IDLE);
    done_o  = (state_q == S_DONE);
    rd_en_o = run;
    state_o = state_q;
  end

  // Address walk uses registered strip/window/row bases so only adders sit in the path.
  always_comb begin
    win_col_d    = win_col_q;
    win_row_d    = win_row_q;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    rd_addr_d    = rd_addr_q;
    row_base_d   = row_base_q;
    win_base_d   = win_base_q;
    strip_base_d = strip_base_q;
    wr_addr_d    = wr_addr_q;
    drain_d      = (state_q == S_DRAIN) ? ~drain_q : 1'b0;
    clr_d        = run && (win_col_q == '0) && (win_row_q == '0);
    last_d       = run && win_last;
    wen_d        = last_q;

    if (wen_q) wr_addr_d = wr_addr_q + 1'b1;

    if ((state_q == S_IDLE) && start_i) begin
      win_col_d    = '0;
      win_row_d    = '0;
      out_col_d    = '0;
      out_row_d    = '0;
      rd_addr_d    = '0;
      row_base_d   = '0;
      win_base_d   = '0;
      strip_base_d = '0;
      wr_addr_d    = '0;
    end else if (run) begin
      if (win_col_q != WIN_MAX) begin
        win_col_d = win_col_q + 1'b1;
        rd_addr_d = rd_addr_q + 1'b1;
      end else begin
        win_col_d = '0;
        if (win_row_q != WIN_MAX) begin
          win_row_d  = win_row_q + 1'b1;
          row_base_d = row_base_q + STEP_ROW;
          rd_addr_d  = row_base_q + STEP_ROW;
        end else begin
          win_row_d = '0;
          if (out_col_q != OC_MAX) begin
            out_col_d  = out_col_q + 1'b1;
            win_base_d = win_base_q + STEP_WIN;
            row_base_d = win_base_q + STEP_WIN;
            rd_addr_d  = win_base_q + STEP_WIN;
          end else begin
            out_col_d = '0;
            if (out_row_q != OR_MAX) begin
              out_row_d    = out_row_q + 1'b1;
              strip_base_d = strip_base_q + STEP_STRIP;
              win_base_d   = strip_base_q + STEP_STRIP;
              row_base_d   = strip_base_q + STEP_STRIP;
              rd_addr_d    = strip_base_q + STEP_STRIP;
            end else begin
              out_row_d    = '0;
              strip_base_d = '0;
              win_base_d   = '0;
              row_base_d   = '0;
              rd_addr_d    = '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drain_q      <= 1'b0;
      win_col_q    <= '0;
      win_row_q    <= '0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      rd_addr_q    <= '0;
      row_base_q   <= '0;
      win_base_q   <= '0;
      strip_base_q <= '0;
      clr_q        <= 1'b0;
      last_q       <= 1'b0;
      wen_q        <= 1'b0;
      wr_addr_q    <= '0;
    end else begin
      drain_q      <= drain_d;
      win_col_q    <= win_col_d;
      win_row_q    <= win_row_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      rd_addr_q    <= rd_addr_d;
      row_base_q   <= row_base_d;
      win_base_q   <= win_base_d;
      strip_base_q <= strip_base_d;
      clr_q        <= clr_d;
      last_q       <= last_d;
      wen_q        <= wen_d;
      wr_addr_q    <= wr_addr_d;
    end
  end

  assign rd_addr_o  = rd_addr_q;
  assign pool_clr_o = clr_q;
  assign wr_en_o    = wen_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = pool_dout_i;

endmodule

// File: tb/tb_pool_ctrl.sv
// Bench for pool_ctrl: a 4x4 instance for cycle-exact scenarios and a 28x28 instance
// for the full-size scan, each fed by a buffer plus running-max pooling model.
module tb_pool_ctrl;

  localparam int SW  = 4;
  localparam int SWN = 2;
  localparam int SN  = SW * SW;
  localparam int SW2 = SWN * SWN;
  localparam int LW  = 28;
  localparam int LN  = LW * LW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Small instance signals
  logic        start_s = 1'b0;
  logic        busy_s, done_s, rd_en_s, pool_clr_s, wr_en_s;
  logic [9:0]  rd_addr_s;
  logic [7:0]  wr_addr_s;
  logic [15:0] pool_dout_s, wr_data_s, in_s;
  logic [1:0]  state_s;
  logic [15:0] mem_s [SN];

  // Large instance signals
  logic        start_l = 1'b0;
  logic        busy_l, done_l, rd_en_l, pool_clr_l, wr_en_l;
  logic [9:0]  rd_addr_l;
  logic [7:0]  wr_addr_l;
  logic [15:0] pool_dout_l, wr_data_l, in_l;
  logic [1:0]  state_l;
  logic [15:0] mem_l [LN];

  pool_ctrl #(.MAP_W(SW), .MAP_H(SW), .WIN(SWN), .RD_AW(10), .WR_AW(8), .DW(16)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start_s), .busy_o(busy_s), .done_o(done_s),
    .rd_en_o(rd_en_s), .rd_addr_o(rd_addr_s), .pool_clr_o(pool_clr_s),
    .pool_dout_i(pool_dout_s), .wr_en_o(wr_en_s), .wr_addr_o(wr_addr_s),
    .wr_data_o(wr_data_s), .state_o(state_s)
  );

  pool_ctrl dut_l (
    .clk_i(clk), .rst_i(rst), .start_i(start_l), .busy_o(busy_l), .done_o(done_l),
    .rd_en_o(rd_en_l), .rd_addr_o(rd_addr_l), .pool_clr_o(pool_clr_l),
    .pool_dout_i(pool_dout_l), .wr_en_o(wr_en_l), .wr_addr_o(wr_addr_l),
    .wr_data_o(wr_data_l), .state_o(state_l)
  );

  // Synchronous-read buffer feeding a running-max unit cleared by pool_clr
  always @(posedge clk) begin
    in_s <= mem_s[rd_addr_s[3:0]];
    if (pool_clr_s || in_s > pool_dout_s) pool_dout_s <= in_s;
    in_l <= mem_l[rd_addr_l];
    if (pool_clr_l || in_l > pool_dout_l) pool_dout_l <= in_l;
  end

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (busy_s !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy_s); end
    n_checks++; if (done_s !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done_s); end
    n_checks++; if (rd_en_s !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %0b expected 0", rd_en_s); end
    n_checks++; if (pool_clr_s !== 1'b0) begin n_fail++; $display("FAIL reset_pool_clr: got %0b expected 0", pool_clr_s); end
    n_checks++; if (wr_en_s !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0b expected 0", wr_en_s); end
    n_checks++; if (rd_addr_s !== 10'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr_s); end
    n_checks++; if (wr_addr_s !== 8'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr_s); end
    n_checks++; if (busy_l !== 1'b0 || rd_en_l !== 1'b0 || wr_en_l !== 1'b0) begin
      n_fail++; $display("FAIL reset_large: got busy %0b rd_en %0b wr_en %0b expected 0 0 0", busy_l, rd_en_l, wr_en_l);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // mode 0: data = address, mode 1: random, mode 2: descending window maxima on first element
  task automatic test_scan(input int mode, input bit pulse_starts);
    logic [9:0]  exp_q[$];
    logic [15:0] exp_data_q[$];
    logic [15:0] m, v, first;
    logic [9:0]  a;
    bit          e_rd, e_clr, e_wen;
    int          widx;
    for (int orow = 0; orow < SW / SWN; orow++)
      for (int oc = 0; oc < SW / SWN; oc++) begin
        first = 16'(200 - 20 * (orow * (SW / SWN) + oc));
        for (int wr = 0; wr < SWN; wr++)
          for (int wc = 0; wc < SWN; wc++) begin
            a = 10'((orow * SWN + wr) * SW + oc * SWN + wc);
            if (mode == 0) mem_s[a[3:0]] = 16'(a);
            else if (mode == 1) mem_s[a[3:0]] = 16'($urandom_range(0, 65535));
            else mem_s[a[3:0]] = (wr == 0 && wc == 0) ? first : 16'($urandom_range(0, int'(first) - 1));
          end
      end
    for (int orow = 0; orow < SW / SWN; orow++)
      for (int oc = 0; oc < SW / SWN; oc++) begin
        m = 16'd0;
        for (int wr = 0; wr < SWN; wr++)
          for (int wc = 0; wc < SWN; wc++) begin
            a = 10'((orow * SWN + wr) * SW + oc * SWN + wc);
            exp_q.push_back(a);
            v = mem_s[a[3:0]];
            if (v > m) m = v;
          end
        exp_data_q.push_back(m);
      end
    @(negedge clk);
    n_checks++; if (busy_s !== 1'b0) begin n_fail++; $display("FAIL scan_idle_busy: got %0b expected 0", busy_s); end
    start_s = 1'b1;
    @(posedge clk);
    widx = 0;
    for (int k = 1; k <= SN + 3; k++) begin
      @(negedge clk);
      start_s = (pulse_starts && (k == 5 || k == 12)) ? 1'b1 : 1'b0;
      e_rd  = (k <= SN);
      e_clr = (k >= 2 && k <= SN + 1 && (k - 2) % SW2 == 0);
      e_wen = (k >= SW2 + 2 && k <= SN + 2 && (k - 2) % SW2 == 0);
      n_checks++; if (busy_s !== 1'b1) begin n_fail++; $display("FAIL scan_busy cycle %0d: got %0b expected 1", k, busy_s); end
      n_checks++; if (done_s !== (k == SN + 3)) begin n_fail++; $display("FAIL scan_done cycle %0d: got %0b expected %0b", k, done_s, (k == SN + 3)); end
      n_checks++; if (rd_en_s !== e_rd) begin n_fail++; $display("FAIL scan_rd_en cycle %0d: got %0b expected %0b", k, rd_en_s, e_rd); end
      if (e_rd) begin
        a = exp_q.pop_front();
        n_checks++; if (rd_addr_s !== a) begin n_fail++; $display("FAIL scan_rd_addr cycle %0d: got %0d expected %0d", k, rd_addr_s, a); end
      end
      n_checks++; if (pool_clr_s !== e_clr) begin n_fail++; $display("FAIL scan_pool_clr cycle %0d: got %0b expected %0b", k, pool_clr_s, e_clr); end
      n_checks++; if (wr_en_s !== e_wen) begin n_fail++; $display("FAIL scan_wr_en cycle %0d: got %0b expected %0b", k, wr_en_s, e_wen); end
      if (e_wen) begin
        m = exp_data_q.pop_front();
        n_checks++; if (wr_addr_s !== 8'(widx)) begin n_fail++; $display("FAIL scan_wr_addr cycle %0d: got %0d expected %0d", k, wr_addr_s, widx); end
        n_checks++; if (wr_data_s !== m) begin n_fail++; $display("FAIL scan_wr_data cycle %0d: got %0d expected %0d", k, wr_data_s, m); end
        widx++;
      end
    end
    start_s = 1'b0;
  endtask

  task automatic test_abort();
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start_s = 1'b0;
    end
    rst = 1'b1;
    #1;
    n_checks++; if (busy_s !== 1'b0 || done_s !== 1'b0 || rd_en_s !== 1'b0) begin
      n_fail++; $display("FAIL abort_ctrl: got busy %0b done %0b rd_en %0b expected 0 0 0", busy_s, done_s, rd_en_s);
    end
    n_checks++; if (pool_clr_s !== 1'b0 || wr_en_s !== 1'b0) begin
      n_fail++; $display("FAIL abort_strobes: got pool_clr %0b wr_en %0b expected 0 0", pool_clr_s, wr_en_s);
    end
    n_checks++; if (rd_addr_s !== 10'd0 || wr_addr_s !== 8'd0) begin
      n_fail++; $display("FAIL abort_addr: got rd_addr %0d wr_addr %0d expected 0 0", rd_addr_s, wr_addr_s);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      n_checks++; if (rd_en_s !== 1'b0 || wr_en_s !== 1'b0 || busy_s !== 1'b0) begin
        n_fail++; $display("FAIL abort_quiet cycle %0d: got rd_en %0b wr_en %0b busy %0b expected 0 0 0", k, rd_en_s, wr_en_s, busy_s);
      end
    end
  endtask

  task automatic test_full();
    logic [9:0]  exp_q[$];
    logic [15:0] exp_data_q[$];
    logic [15:0] m;
    logic [9:0]  a;
    int n_rd, n_wr, done_cycle;
    for (int i = 0; i < LN; i++) mem_l[i] = 16'($urandom_range(0, 65535));
    for (int orow = 0; orow < LW / 2; orow++)
      for (int oc = 0; oc < LW / 2; oc++) begin
        m = 16'd0;
        for (int wr = 0; wr < 2; wr++)
          for (int wc = 0; wc < 2; wc++) begin
            a = 10'((orow * 2 + wr) * LW + oc * 2 + wc);
            exp_q.push_back(a);
            if (mem_l[a] > m) m = mem_l[a];
          end
        exp_data_q.push_back(m);
      end
    n_rd = 0;
    n_wr = 0;
    done_cycle = -1;
    @(negedge clk);
    start_l = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= LN + 40; k++) begin
      @(negedge clk);
      start_l = 1'b0;
      if (rd_en_l) begin
        a = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
        n_checks++; if (rd_addr_l !== a) begin n_fail++; $display("FAIL full_rd_addr cycle %0d: got %0d expected %0d", k, rd_addr_l, a); end
        n_rd++;
      end
      if (wr_en_l) begin
        m = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : 16'hxxxx;
        n_checks++; if (wr_addr_l !== 8'(n_wr)) begin n_fail++; $display("FAIL full_wr_addr cycle %0d: got %0d expected %0d", k, wr_addr_l, n_wr); end
        n_checks++; if (wr_data_l !== m) begin n_fail++; $display("FAIL full_wr_data cycle %0d: got %0d expected %0d", k, wr_data_l, m); end
        n_wr++;
      end
      if (done_l) begin
        done_cycle = k;
        break;
      end
    end
    n_checks++; if (n_rd != LN) begin n_fail++; $display("FAIL full_reads: got %0d expected %0d", n_rd, LN); end
    n_checks++; if (n_wr != LN / 4) begin n_fail++; $display("FAIL full_writes: got %0d expected %0d", n_wr, LN / 4); end
    n_checks++; if (done_cycle != LN + 3) begin n_fail++; $display("FAIL full_done_cycle: got %0d expected %0d", done_cycle, LN + 3); end
  endtask

  initial begin
    test_reset();
    test_scan(0, 1'b0);
    test_scan(2, 1'b0);
    test_scan(1, 1'b1);
    test_scan(1, 1'b0);
    test_abort();
    test_scan(0, 1'b0);
    test_full();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
